// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding and master IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the memory arbiter: request fields in, ack/read data out.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker: on a tie the master that did not go last wins.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_owner_i,
  output logic valid_o,
  output logic winner_o
);

  // Winner selection
  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      winner_o = ~last_owner_i;
    end else if (req1_i) begin
      winner_o = 1'b1;
    end else begin
      winner_o = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and loader accesses onto the single-port unified memory,
// returning a one-cycle ack and held read data to the transaction owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_arbiter_if.slave      m0_if,
  mem_arbiter_if.slave      m1_if,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              grant_valid_s;
  logic              grant_owner_s;

  rr_arb2 u_rr_arb2 (
    .req0_i       (m0_if.req),
    .req1_i       (m1_if.req),
    .last_owner_i (last_owner_q),
    .valid_o      (grant_valid_s),
    .winner_o     (grant_owner_s)
  );

  // State and datapath registers; last_owner resets to 1 so the CPU wins the first tie
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          state_d = ISSUE;
          owner_d = grant_owner_s;
          if (grant_owner_s == M_LDR) begin
            we_d    = m1_if.we;
            addr_d  = m1_if.addr;
            wdata_d = m1_if.wdata;
          end else begin
            we_d    = m0_if.we;
            addr_d  = m0_if.addr;
            wdata_d = m0_if.wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Memory data is only valid on the last latency cycle
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          if (we_q) begin
            rdata0_d = rdata0_q;
          end else if (owner_q == M_LDR) begin
            rdata1_d = mem_rdata_i;
          end else begin
            rdata0_d = mem_rdata_i;
          end
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    mem_en_o    = 1'b0;
    busy_o      = 1'b1;
    m0_if.ack   = 1'b0;
    m1_if.ack   = 1'b0;
    case (state_q)
      IDLE:  busy_o   = 1'b0;
      ISSUE: mem_en_o = 1'b1;
      WAIT:  busy_o   = 1'b1;
      RESP: begin
        if (owner_q == M_LDR) begin
          m1_if.ack = 1'b1;
        end else begin
          m0_if.ack = 1'b1;
        end
      end
      default: busy_o = 1'b0;
    endcase
    mem_we_o    = we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    owner_o     = owner_q;
    m0_if.rdata = rdata0_q;
    m1_if.rdata = rdata1_q;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter and sequencer for the unified single-port instruction/data memory of the 16-bit multi-cycle processor. Master 0 is the CPU memory port, carrying both IorD-selected instruction fetches and load/store traffic; master 1 is the program loader/DMA port. The block owns the memory port, serialises one access at a time, and grants round-robin on contention. It returns read data and a one-cycle acknowledge to the winner, so the CPU FSM can hold its memory state until acknowledged.

## Interface
- ADDR_W, 16, memory word-address width
- DATA_W, 16, data width
- MEM_LAT, 1, memory read latency in cycles (>=1): mem_rdata valid MEM_LAT cycles after the mem_en cycle
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- m0_req / m1_req  in  1  access request, held until ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DATA_W  registered read data, valid with ack, held until next read by that master
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in flight (state != IDLE)
- owner  out  1  master ID of current/last transaction

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req, pick a winner, latch its we/addr/wdata into request registers, set owner, go to ISSUE. Otherwise stay.
- Pick: a single requester wins. With both requesting, the master != last_owner wins. last_owner resets to 1, so master 0 wins the first tie.
- ISSUE: mem_en=1, mem_we/addr/wdata driven from latched registers. Load latency counter with MEM_LAT. Go to WAIT.
- WAIT: decrement counter. On the cycle the counter reaches 1, capture mem_rdata into owner's rdata register if read. Go to RESP.
- RESP: ack of owner = 1 for exactly this cycle, last_owner <= owner, go to IDLE.
- Writes follow the same flow; rdata registers are untouched on writes.
- Requester contract: fields stable while req high and before ack. After ack, req may stay high only for a new request, which is sampled in the following IDLE cycle.
- Non-owner req is ignored until IDLE. The losing master is guaranteed service as the next transaction.
- mem_we, mem_addr and mem_wdata hold their last values outside ISSUE; only mem_en qualifies them.

## Timing
- Req seen in IDLE at cycle t, then ISSUE at t+1, WAIT at t+2..t+1+MEM_LAT, ack at t+2+MEM_LAT, IDLE at t+3+MEM_LAT.
- Transaction period is 3+MEM_LAT cycles. With MEM_LAT=1, the period is 4 cycles and ack comes 3 cycles after the IDLE request cycle.
- Never more than one ack per cycle. Never ack without a preceding mem_en for that owner.
- Reset values: all outputs 0, state IDLE, last_owner 1, counter 0, request and rdata registers 0.
- Reset mid-transaction: next cycle is IDLE with all outputs 0. The transaction is abandoned with no ack. A write already strobed may have completed, and the requester must reissue.
- Simultaneous req and reset: reset wins, and req is sampled in the first post-reset IDLE cycle.

## Structure
- Package mem_arb_pkg: state enum {IDLE, ISSUE, WAIT, RESP}, master ID constants M_CPU=0 and M_LDR=1.
- Sub-module rr_arb2: combinational two-input round-robin picker (req0, req1, last_owner -> valid, winner).
- The FSM, counter and registers live in mem_arbiter.

## Test plan
- Reset, then m0 read addr 0x0010 with memory returning 0xBEEF (MEM_LAT=1): mem_en at t+1 with addr 0x0010 and we=0; m0_ack at t+3; m0_rdata=0xBEEF.
- m1 write addr 0x0020, data 0x1234: single mem_en with mem_we=1, addr 0x0020, wdata 0x1234; m1_ack 3 cycles after request; m1_rdata unchanged.
- Both req in the same cycle after reset: m0 served first. m1 gets mem_en in the first ISSUE after m0_ack; acks alternate m0, m1, m0, m1 under continuous contention.
- MEM_LAT=3, m0 read: ack 5 cycles after the request cycle; rdata captured from the memory's 3rd-cycle value, not earlier values.
- Reset asserted during WAIT of an m1 read: no m1_ack; outputs 0 next cycle. A subsequent m1 request completes normally with correct data.
- Continuous m0 requests with m1 asserting mid-stream: m1 is granted in the next IDLE; m0 never receives two consecutive grants while m1 is pending.
